// File: rtl/axis_video_stream_mon.sv
// AXI4-Stream video passthrough monitor: geometry, rate and error statistics behind a registered read port.
// Define AXIS_MON_STALL_CNT_EN to build the per-window source-starve / sink-backpressure counters.
module axis_video_stream_mon #(
    parameter int DATA_WIDTH  = 48,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 4,
    parameter int FREQ_HZ     = 100000000,
    parameter int MIN_FPS     = 3,
    parameter int GEO_WIDTH   = 16
) (
    input  logic                   aclk,
    input  logic                   areset,

    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
    input  logic [TDEST_WIDTH-1:0] s_axis_tdest,

    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [TDEST_WIDTH-1:0] m_axis_tdest,

    input  logic [GEO_WIDTH-1:0]   cfg_width,
    input  logic [GEO_WIDTH-1:0]   cfg_height,
    input  logic                   err_clr,
    input  logic [2:0]             rd_addr,
    output logic [31:0]            rd_data,
    output logic                   stream_ok,
    output logic                   err_irq
);

    localparam int WIN_W = (FREQ_HZ > 1) ? $clog2(FREQ_HZ) : 1;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic inc);
        return (&a) ? a : a + {31'b0, inc};
    endfunction

    // The data path is wires only, so the monitor can never disturb the video.
    assign m_axis_tvalid = s_axis_tvalid;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = s_axis_tuser;
    assign m_axis_tdest  = s_axis_tdest;
    assign s_axis_tready = m_axis_tready;

    logic beat, sof, eol, tick;
    assign beat = s_axis_tvalid & m_axis_tready;
    assign sof  = beat & s_axis_tuser[0];
    assign eol  = beat & s_axis_tlast;

    logic [WIN_W-1:0]     win_cnt;
    logic [GEO_WIDTH-1:0] col_cnt, col_inc, line_cnt, line_base, line_next;
    logic [GEO_WIDTH-1:0] line_len, frame_lines;
    logic [31:0]          frame_beat_cnt, frame_beats;
    logic [31:0]          fps_cnt, sec_beat_cnt, fps, beats_per_sec;
    logic [31:0]          fps_sum, beat_sum;
    logic [31:0]          stall_src, stall_snk;
    logic [31:0]          rd_next;
    logic                 frame_seen, col_sat;
    logic                 err_width, err_height, err_sof_mid;
    logic                 width_evt, height_evt, sof_mid_evt;

    assign tick      = (win_cnt == WIN_W'(FREQ_HZ - 1));
    assign col_sat   = &col_cnt;
    assign col_inc   = col_sat ? col_cnt : col_cnt + GEO_WIDTH'(1);
    assign line_base = sof ? '0 : line_cnt;
    assign line_next = (eol && !(&line_base)) ? line_base + GEO_WIDTH'(1) : line_base;
    assign fps_sum   = sat_add32(fps_cnt, sof);
    assign beat_sum  = sat_add32(sec_beat_cnt, beat);

    assign width_evt   = (eol && (cfg_width != '0) && (col_inc != cfg_width)) || col_sat;
    assign height_evt  = sof && frame_seen && (cfg_height != '0) && (line_cnt != cfg_height);
    assign sof_mid_evt = sof && (col_cnt != '0);

    // Per-window counters restart at this cycle's event so a tick-cycle event lands in both windows.
    always_ff @(posedge aclk) begin
        if (areset) begin
            win_cnt       <= '0;
            fps_cnt       <= '0;
            sec_beat_cnt  <= '0;
            fps           <= '0;
            beats_per_sec <= '0;
            stream_ok     <= 1'b0;
        end else begin
            win_cnt <= tick ? '0 : win_cnt + WIN_W'(1);
            if (tick) begin
                fps           <= fps_sum;
                beats_per_sec <= beat_sum;
                stream_ok     <= (fps_sum >= 32'(MIN_FPS));
                fps_cnt       <= {31'b0, sof};
                sec_beat_cnt  <= {31'b0, beat};
            end else begin
                fps_cnt      <= fps_sum;
                sec_beat_cnt <= beat_sum;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            col_cnt        <= '0;
            line_len       <= '0;
            line_cnt       <= '0;
            frame_lines    <= '0;
            frame_beat_cnt <= '0;
            frame_beats    <= '0;
            frame_seen     <= 1'b0;
        end else begin
            if (eol) begin
                line_len <= col_inc;
                col_cnt  <= '0;
            end else if (beat) begin
                col_cnt <= col_inc;
            end
            if (beat) begin
                line_cnt <= line_next;
            end
            // The first SOF after reset only arms latching; there is no complete frame behind it yet.
            if (sof) begin
                frame_beat_cnt <= 32'd1;
                frame_seen     <= 1'b1;
                if (frame_seen) begin
                    frame_lines <= line_cnt;
                    frame_beats <= frame_beat_cnt;
                end
            end else if (beat) begin
                frame_beat_cnt <= sat_add32(frame_beat_cnt, 1'b1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            err_sof_mid <= 1'b0;
            err_irq     <= 1'b0;
        end else begin
            err_width   <= (err_width   & ~err_clr) | width_evt;
            err_height  <= (err_height  & ~err_clr) | height_evt;
            err_sof_mid <= (err_sof_mid & ~err_clr) | sof_mid_evt;
            err_irq     <= err_width | err_height | err_sof_mid;
        end
    end

`ifdef AXIS_MON_STALL_CNT_EN
    logic [31:0] src_cnt, snk_cnt;
    logic        src_evt, snk_evt;
    assign src_evt = ~s_axis_tvalid & m_axis_tready;
    assign snk_evt = s_axis_tvalid & ~m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            src_cnt   <= '0;
            snk_cnt   <= '0;
            stall_src <= '0;
            stall_snk <= '0;
        end else if (tick) begin
            stall_src <= sat_add32(src_cnt, src_evt);
            stall_snk <= sat_add32(snk_cnt, snk_evt);
            src_cnt   <= {31'b0, src_evt};
            snk_cnt   <= {31'b0, snk_evt};
        end else begin
            src_cnt <= sat_add32(src_cnt, src_evt);
            snk_cnt <= sat_add32(snk_cnt, snk_evt);
        end
    end
`else
    assign stall_src = '0;
    assign stall_snk = '0;
`endif

    // Measurements are hidden until the stream has proven itself alive for a full window.
    always_comb begin
        rd_next = '0;
        case (rd_addr)
            3'd0: rd_next = 32'(line_len);
            3'd1: rd_next = 32'(frame_lines);
            3'd2: rd_next = fps;
            3'd3: rd_next = beats_per_sec;
            3'd4: rd_next = frame_beats;
            3'd5: rd_next = {26'b0, err_sof_mid, err_height, err_width, 2'b0, stream_ok};
            3'd6: rd_next = stall_src;
            3'd7: rd_next = stall_snk;
            default: rd_next = '0;
        endcase
        if (!stream_ok && (rd_addr <= 3'd4)) begin
            rd_next = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_axis_video_stream_mon.sv
// Directed self-checking bench for axis_video_stream_mon (1000-cycle window, MIN_FPS=3).
module tb_axis_video_stream_mon;

    localparam int FREQ = 1000;

    logic        aclk = 1'b0;
    logic        areset;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [47:0] s_axis_tdata;
    logic [0:0]  s_axis_tuser;
    logic [3:0]  s_axis_tdest;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [47:0] m_axis_tdata;
    logic [0:0]  m_axis_tuser;
    logic [3:0]  m_axis_tdest;
    logic [15:0] cfg_width, cfg_height;
    logic        err_clr;
    logic [2:0]  rd_addr;
    logic [31:0] rd_data;
    logic        stream_ok, err_irq;

    int tests = 0;
    int fails = 0;
    int kcnt  = 0;

    axis_video_stream_mon #(
        .DATA_WIDTH(48), .TUSER_WIDTH(1), .TDEST_WIDTH(4),
        .FREQ_HZ(FREQ), .MIN_FPS(3), .GEO_WIDTH(16)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_tuser(s_axis_tuser), .s_axis_tdest(s_axis_tdest),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tdest(m_axis_tdest),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .err_clr(err_clr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .stream_ok(stream_ok), .err_irq(err_irq)
    );

    always #5 aclk = ~aclk;

    // kcnt is the index of the next non-reset cycle, so kcnt % FREQ mirrors the window position.
    task automatic step();
        @(posedge aclk);
        if (areset) kcnt = 0;
        else        kcnt++;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic u, input logic l,
                                  input logic r, input logic [47:0] d);
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        m_axis_tready = r;
        s_axis_tdata  = d;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 48'h0);
    endtask

    task automatic wait_until(input int k);
        while (kcnt < k) idle(1);
    endtask

    task automatic align_window();
        while (kcnt % FREQ != 0) idle(1);
    endtask

    task automatic send_frame(input int w, input int h);
        for (int l = 0; l < h; l++)
            for (int c = 0; c < w; c++)
                apply_stimulus(1'b1, (l == 0 && c == 0), (c == w - 1), 1'b1, 48'(l * 256 + c));
    endtask

    task automatic send_line(input int w, input logic clr_on_last);
        for (int c = 0; c < w; c++) begin
            err_clr = clr_on_last && (c == w - 1);
            apply_stimulus(1'b1, 1'b0, (c == w - 1), 1'b1, 48'(c));
        end
        err_clr = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        rd_addr = a;
        idle(1);
        check_output(tag, rd_data, exp);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
    endtask

    initial begin : stim
        int base;
        int b;
        int mcount;
        int bad;
        logic [47:0] d;
        logic [31:0] snk_exp;

        areset = 1'b1; err_clr = 1'b0; rd_addr = 3'd0;
        cfg_width = 16'd8; cfg_height = 16'd4;
        s_axis_tdest = 4'd0;
        idle(3);
        check_output("rst_stream_ok", {31'b0, stream_ok}, 32'd0);
        check_output("rst_irq", {31'b0, err_irq}, 32'd0);

        // A partial frame with an SOF mid-line raises an error before the reset hits.
        areset = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 48'h1);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1, 48'h2);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 48'h3);
        idle(1);
        check_output("pre_reset_irq", {31'b0, err_irq}, 32'd1);

        areset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = {16'hA5A5 ^ 16'(i), 32'hDEADBEEF + 32'(i)};
            s_axis_tvalid = (i != 1);
            s_axis_tlast  = (i == 1);
            s_axis_tuser  = (i != 1);
            s_axis_tdest  = 4'(i + 3);
            m_axis_tready = (i != 2);
            s_axis_tdata  = d;
            #1;
            check_output("pass_data_lo", m_axis_tdata[31:0], d[31:0]);
            check_output("pass_data_hi", {16'b0, m_axis_tdata[47:32]}, {16'b0, d[47:32]});
            check_output("pass_ctrl", {24'b0, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdest, s_axis_tready},
                         {24'b0, (i != 1), (i == 1), (i != 1), 4'(i + 3), (i != 2)});
            step();
        end
        areset = 1'b0;
        s_axis_tdest = 4'd0;
        for (int a = 0; a < 8; a++) check_reg("post_reset_reg", 3'(a), 32'd0);
        check_output("post_reset_stream_ok", {31'b0, stream_ok}, 32'd0);
        check_output("post_reset_irq", {31'b0, err_irq}, 32'd0);

        // Nominal: 8x4 frames every 200 cycles, two full windows.
        align_window();
        base = kcnt;
        for (int f = 0; f < 10; f++) begin
            wait_until(base + 200 * f);
            send_frame(8, 4);
        end
        wait_until(base + 2000);
        check_reg("nom_line_len", 3'd0, 32'd8);
        check_reg("nom_frame_lines", 3'd1, 32'd4);
        check_reg("nom_fps", 3'd2, 32'd5);
        check_reg("nom_bps", 3'd3, 32'd160);
        check_reg("nom_frame_beats", 3'd4, 32'd32);
        check_reg("nom_status", 3'd5, 32'd1);
        check_output("nom_irq", {31'b0, err_irq}, 32'd0);

        // SOF on the tick cycle is counted in both the closing and the new window.
        wait_until(base + 2500); send_frame(8, 4);
        wait_until(base + 2700); send_frame(8, 4);
        wait_until(base + 2999); send_frame(8, 4);
        check_reg("tick_fps", 3'd2, 32'd3);
        check_reg("tick_bps", 3'd3, 32'd65);
        check_output("tick_stream_ok", {31'b0, stream_ok}, 32'd1);
        wait_until(base + 3500); send_frame(8, 4);
        wait_until(base + 3700); send_frame(8, 4);
        wait_until(base + 4000);
        check_reg("carry_fps", 3'd2, 32'd3);
        check_reg("carry_bps", 3'd3, 32'd96);
        wait_until(base + 4500); send_frame(8, 4);
        wait_until(base + 4700); send_frame(8, 4);
        wait_until(base + 5000);
        check_output("low_fps_stream_ok", {31'b0, stream_ok}, 32'd0);
        for (int a = 0; a < 5; a++) check_reg("low_fps_hidden", 3'(a), 32'd0);
        check_reg("low_fps_status", 3'd5, 32'd0);

        // Width error, irq latency, clear, and clear colliding with a new error.
        send_line(7, 1'b0);
        check_output("werr_irq_lag", {31'b0, err_irq}, 32'd0);
        idle(1);
        check_output("werr_irq", {31'b0, err_irq}, 32'd1);
        check_reg("werr_flags", 3'd5, 32'h8);
        pulse_clr();
        check_reg("clr_flags", 3'd5, 32'h0);
        check_output("clr_irq", {31'b0, err_irq}, 32'd0);
        send_line(7, 1'b1);
        check_reg("clr_vs_err_flags", 3'd5, 32'h8);
        check_output("clr_vs_err_irq", {31'b0, err_irq}, 32'd1);
        pulse_clr();
        send_frame(8, 3);
        send_frame(8, 4);
        idle(1);
        check_reg("herr_flags", 3'd5, 32'h10);

        // Backpressure: tready toggles every cycle for one full window with tvalid held high.
        align_window();
        b = 0; mcount = 0; bad = 0;
        for (int k = 0; k < FREQ; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tuser  = (b % 32 == 0);
            s_axis_tlast  = (b % 8 == 7);
            s_axis_tdata  = 48'h5A0000000000 + 48'(b);
            m_axis_tready = (k % 2 == 0);
            #1;
            if (m_axis_tvalid && m_axis_tready) begin
                mcount++;
                if (m_axis_tdata !== 48'h5A0000000000 + 48'(b)) bad++;
                b++;
            end
            step();
        end
        check_output("bp_out_beats", 32'(mcount), 32'd500);
        check_output("bp_out_data_errs", 32'(bad), 32'd0);
        check_reg("bp_bps", 3'd3, 32'd500);
        check_reg("bp_fps", 3'd2, 32'd16);
`ifdef AXIS_MON_STALL_CNT_EN
        snk_exp = 32'd500;
`else
        snk_exp = 32'd0;
`endif
        check_reg("bp_stall_snk", 3'd7, snk_exp);
        check_reg("bp_stall_src", 3'd6, 32'd0);

        // Saturation: one endless line, SOFs sprinkled in so the stream stays valid.
        cfg_width = 16'd0; cfg_height = 16'd0;
        pulse_clr();
        rd_addr = 3'd5;
        for (int n = 0; n < 65600; n++) begin
            apply_stimulus(1'b1, (n % 200 == 0), 1'b0, 1'b1, 48'(n));
            if (n == 1000) check_output("sat_early_werr", {31'b0, rd_data[3]}, 32'd0);
        end
        check_output("sat_werr", {31'b0, rd_data[3]}, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 48'h0);
        check_reg("sat_line_len", 3'd0, 32'h0000FFFF);
        check_output("sat_irq", {31'b0, err_irq}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_video_stream_mon.md
Name: axis_video_stream_mon

Overview:
- Parametrised successor to the single-stream AXI4-Stream passthrough monitor.
- Forwards a video AXI4-Stream unchanged, with zero latency and no added logic in the data path.
- Measures line length, frame height, frames per second, beats per frame and beats per second.
- New in this generation: checks geometry against configured width/height with sticky error flags, uses a saturating counter policy, and exposes all results through a registered read port for a host-side register wrapper.

Parameters:
- DATA_WIDTH, 48, tdata width.
- TUSER_WIDTH, 1, tuser width; bit 0 is SOF.
- TDEST_WIDTH, 4, tdest width.
- FREQ_HZ, 100000000, aclk frequency; the measurement window is exactly FREQ_HZ cycles.
- MIN_FPS, 3, minimum frames per window for the stream to be reported valid.
- GEO_WIDTH, 16, width of the column/line counters and of cfg_width/cfg_height.

Ports:
- aclk  in  1  sole clock.
- areset  in  1  synchronous reset, active-high.
- s_axis_tvalid/tready/tdata/tlast/tuser/tdest  in/out/in/in/in/in  1/1/DATA_WIDTH/1/TUSER_WIDTH/TDEST_WIDTH  upstream stream.
- m_axis_tvalid/tready/tdata/tlast/tuser/tdest  out/in/out/out/out/out  same widths  downstream stream.
- cfg_width  in  GEO_WIDTH  expected beats per line; 0 disables the width check.
- cfg_height  in  GEO_WIDTH  expected lines per frame; 0 disables the height check.
- err_clr  in  1  one-cycle pulse that clears the sticky error flags.
- rd_addr  in  3  register select.
- rd_data  out  32  selected register value, registered.
- stream_ok  out  1  last window's frame count >= MIN_FPS.
- err_irq  out  1  OR of all sticky error flags.

Behaviour:
- Passthrough is purely combinational: m_* = s_*, s_axis_tready = m_axis_tready. It is unaffected by areset.
- Event definitions:
  - beat = s_axis_tvalid & m_axis_tready.
  - sof = beat & s_axis_tuser[0].
  - eol = beat & s_axis_tlast.
- Reset (areset=1 at a clock edge): every counter, latched value, flag, rd_data, stream_ok and err_irq goes to 0. Also clears frame_seen. Reset mid-frame discards partial counts.
- Window tick:
  - win_cnt counts 0..FREQ_HZ-1; tick=1 in the cycle win_cnt==FREQ_HZ-1, then win_cnt wraps to 0.
- Column counter col_cnt:
  - beat without eol: col_cnt+1.
  - eol: line_len <= col_cnt+1 and col_cnt <= 0.
  - If col_cnt+1 != cfg_width and cfg_width != 0, set err_width.
- Line counter:
  - line_cnt_next = (sof ? 0 : line_cnt) + eol. A single-beat line carrying both sof and eol gives 1.
  - On sof with frame_seen=1: frame_lines <= line_cnt. If cfg_height != 0 and line_cnt != cfg_height, set err_height.
  - The first sof after reset only sets frame_seen; nothing is latched.
- Beats per frame: frame_beat_cnt restarts on sof, with the sof beat counted as 1. On sof with frame_seen=1, frame_beats <= frame_beat_cnt.
- Per-window counts:
  - fps_cnt counts sof; sec_beat_cnt counts beat.
  - On tick: fps <= fps_cnt + sof, beats_per_sec <= sec_beat_cnt + beat, and stream_ok <= (fps_cnt+sof >= MIN_FPS).
  - The counters then restart at the current-cycle event value (0 or 1), so no event is lost at the window boundary.
- Saturation: all counters saturate at all-ones and never wrap. A saturated col_cnt also sets err_width.
- Sticky errors:
  - err_width, err_height, and err_sof_mid (sof while col_cnt != 0, i.e. SOF not at line start).
  - err_clr clears them. If err_clr and a new error occur in the same cycle, the error wins.
  - err_irq is registered, one cycle after the flag sets.
- Read port: rd_data is registered with 1-cycle latency from rd_addr. Map:
  - 0: line_len
  - 1: frame_lines
  - 2: fps
  - 3: beats_per_sec
  - 4: frame_beats
  - 5: {26'b0, err_sof_mid, err_height, err_width, 2'b0, stream_ok}
  - 6: stall_src
  - 7: stall_snk
- Addresses 0-4 read 0 while stream_ok=0. Unimplemented fields read 0; GEO_WIDTH values are zero-extended.

Optional Feature:
- AXIS_MON_STALL_CNT_EN defined:
  - stall_src counts cycles with s_axis_tvalid=0 & m_axis_tready=1 (source starved).
  - stall_snk counts cycles with s_axis_tvalid=1 & m_axis_tready=0 (sink backpressure).
  - Both are 32-bit, accumulate per window, latch on tick (including the tick-cycle event), and saturate.
- Not defined: neither counter is built, and addresses 6/7 read 0.

Test Plan:
- Reset behaviour: hold areset 3 cycles mid-frame, then release -> all rd_data addresses read 0, stream_ok=0, err_irq=0; passthrough stays bit-exact throughout.
- Nominal frames: FREQ_HZ=1000, 8x4 frames with tready=1, cfg 8/4, 5 frames per window -> line_len=8, frame_lines=4, frame_beats=32, fps=5, stream_ok=1, err_irq=0.
- Geometry errors: one 7-beat line with cfg_width=8 -> err_width=1, err_irq=1 on the next cycle. Pulse err_clr -> 0. Then err_clr coincident with a bad eol -> flag stays 1.
- Window boundary: sof lands exactly on the tick cycle -> counted in the closing window's fps, and the new window starts at fps_cnt=1. 2 frames per window with MIN_FPS=3 -> stream_ok=0 and addresses 0-4 read 0.
- Backpressure (AXIS_MON_STALL_CNT_EN): tready toggles 50% over a 1000-cycle window with tvalid=1 -> stall_snk=500, beats_per_sec=500, no data lost or duplicated at m_axis.
- Saturation: cfg_width=0 and a line held without tlast past 2^16 beats -> col_cnt stays 0xFFFF, err_width=1.
